dbus_nslave_interconnect: RTL
=============================

Name: dbus_nslave_interconnect

Overview:
Parametrised, registered data-bus interconnect between the core LSU and NUM_SLAVES peripheral slaves (DMEM, BMEM, CLINT, PLIC, UARTs, and future devices). It decodes addresses against a parameter-defined base/mask map and formats store data and byte selects. A transaction FSM holds the slave handshake until the slave acknowledges. Unmapped, misaligned and timed-out accesses return a one-cycle error response, and the faulting address is captured in a sticky register.

Parameters:
NUM_SLAVES, 6, number of slave ports (1..16)
ADDR_W, 32, bus address width
DATA_W, 32, data width; fixed at 32 in this generation
SLV_BASE, {NUM_SLAVES{ADDR_W'0}}, packed base address per slave; slave i uses bits [i*ADDR_W +: ADDR_W]
SLV_MASK, {NUM_SLAVES{ADDR_W'0}}, packed compare mask per slave; slave i matches when (addr & mask_i) == (base_i & mask_i)
TIMEOUT_CYC, 255, BUSY cycles before a timeout error; 0 disables the timeout

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
ld_req_i  in  1  load request from LSU; held until ack_o
st_req_i  in  1  store request from LSU; held until ack_o
addr_i  in  ADDR_W  request address
w_data_i  in  32  store data, right-aligned
st_ops_i  in  2  store op as ST_OPS_SB/SH/SW from the ISA defines
ack_o  out  1  one-cycle response strobe to LSU
r_data_o  out  32  registered read data, valid with ack_o
err_o  out  1  response is an error, valid with ack_o
err_code_o  out  2  00 none, 01 unmapped, 10 timeout, 11 misaligned; valid with ack_o
cyc_o  out  1  bus cycle active to slaves
stb_o  out  1  strobe to selected slave
w_en_o  out  1  write enable
addr_o  out  ADDR_W  latched address
w_data_o  out  32  lane-formatted store data
sel_byte_o  out  4  byte lane selects
sel_o  out  NUM_SLAVES  one-hot slave select
s_ack_i  in  NUM_SLAVES  slave acknowledges
s_r_data_i  in  NUM_SLAVES*32  slave read data; slave i at [i*32 +: 32]
err_valid_o  out  1  sticky error flag
err_addr_o  out  ADDR_W  address of the first error since the last clear
err_clr_i  in  1  clears err_valid_o

Behaviour:
- Reset: FSM to IDLE. All outputs are 0, including ack_o, err_o, err_code_o, cyc_o, stb_o, sel_o, r_data_o, err_valid_o and err_addr_o. The timeout counter is 0.
- Decode: priority is by lowest index; the first matching slave wins. No match means unmapped.
- Alignment: SH with addr[0]=1 is misaligned. SW, or a load, with addr[1:0]!=0 is misaligned. Loads are always full-word reads.
- Store formatting:
  - SB: data byte replicated into lane addr[1:0]; sel is the one-hot of addr[1:0].
  - SH: lane addr[1]; sel is 0011 or 1100.
  - SW: full word; sel is 1111.
  - Loads: sel is 1111 and w_data_o is 0.
- FSM states:
  - IDLE: on (ld_req_i|st_req_i), latch addr, ops, data, w_en=st_req_i and the decode result.
    - Unmapped or misaligned: go to RESP with the matching error code. No slave is strobed.
    - Otherwise: go to BUSY.
    - If ld_req_i and st_req_i are both high, the store wins.
  - BUSY: cyc_o=stb_o=1 and sel_o is the latched one-hot. The counter increments each cycle.
    - On s_ack_i[sel]: capture s_r_data_i[sel] into r_data_o and go to RESP with err=0.
    - On counter==TIMEOUT_CYC-1 with no ack: go to RESP with code 10 and r_data_o=0.
    - If the ack and the timeout fall in the same cycle, the ack wins.
    - Acks on non-selected slaves are ignored.
  - RESP: ack_o=1 for exactly one cycle, with r_data_o/err_o/err_code_o valid. cyc_o, stb_o and sel_o are 0. Next state is IDLE; the counter is cleared.
- Handshake: the LSU deasserts its request in the cycle after ack_o. IDLE samples requests only, so a request still high in the RESP cycle is not re-accepted.
- Latency:
  - Request seen in IDLE at cycle 0; BUSY from cycle 1.
  - A slave ack at cycle k gives ack_o at cycle k+1.
  - Error-in-decode gives ack_o at cycle 1.
- Sticky error: on entering RESP with an error, if err_valid_o=0, set err_valid_o and load err_addr_o. Later errors do not overwrite.
- err_clr_i: clears err_valid_o next cycle. If a clear and a new error coincide, the set wins and err_addr_o is updated.
- Reset mid-operation: returns to IDLE immediately with all outputs zero. No ack_o is issued for the aborted transaction.
- Unused bits of r_data_o are 0 on error responses.

Test Plan:
- Load word addr 0x8000_0004 → map slave 0 (DMEM) base 0x8000_0000/mask 0xF000_0000. Slave 0 acks 2 cycles after BUSY entry with 0xDEAD_BEEF. Required: sel_o=0x01 and sel_byte_o=1111, then ack_o one cycle later with r_data_o=0xDEADBEEF and err_o=0.
- SB data 0xA5 to addr 0x0200_0003 (CLINT, slave 2) → w_data_o=0xA5A5A5A5, sel_byte_o=1000, w_en_o=1, sel_o=0x04.
- Load from unmapped 0x5000_0000 → no stb_o, ack_o at cycle 1 with err_code_o=01. Then err_valid_o=1 and err_addr_o=0x50000000.
- SH to addr 0x8000_0001 → ack_o at cycle 1 with err_code_o=11 and no slave strobe. A second error then leaves err_addr_o unchanged until err_clr_i is pulsed.
- TIMEOUT_CYC=4, slave never acks → stb_o high for 4 cycles, then ack_o with err_code_o=10 and r_data_o=0. Separately, an ack in the 4th cycle → normal response with err_o=0.
- Assert rst while in BUSY → all outputs 0 immediately and no ack_o. A new request after reset completes normally.

Source files
------------

// File: rtl/dbus_nslave_interconnect.sv
// Registered LSU-to-slave data-bus interconnect: base/mask address decode,
// store lane formatting, a single-outstanding transaction FSM with timeout,
// and a sticky first-error address capture.
module dbus_nslave_interconnect #(
    parameter int                           NUM_SLAVES  = 6,
    parameter int                           ADDR_W      = 32,
    parameter int                           DATA_W      = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE    = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK    = '0,
    parameter int                           TIMEOUT_CYC = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_req_i,
    input  logic                         st_req_i,
    input  logic [ADDR_W-1:0]            addr_i,
    input  logic [DATA_W-1:0]            w_data_i,
    input  logic [1:0]                   st_ops_i,
    output logic                         ack_o,
    output logic [DATA_W-1:0]            r_data_o,
    output logic                         err_o,
    output logic [1:0]                   err_code_o,
    output logic                         cyc_o,
    output logic                         stb_o,
    output logic                         w_en_o,
    output logic [ADDR_W-1:0]            addr_o,
    output logic [DATA_W-1:0]            w_data_o,
    output logic [3:0]                   sel_byte_o,
    output logic [NUM_SLAVES-1:0]        sel_o,
    input  logic [NUM_SLAVES-1:0]        s_ack_i,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_r_data_i,
    output logic                         err_valid_o,
    output logic [ADDR_W-1:0]            err_addr_o,
    input  logic                         err_clr_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [1:0] ST_OPS_SB = 2'b00;
    localparam logic [1:0] ST_OPS_SH = 2'b01;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_MISALIGN = 2'b11;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   cnt;

    logic               req;
    logic               dec_hit;
    logic [IDX_W-1:0]   dec_idx;
    logic               misalign;
    logic [DATA_W-1:0]  fmt_data;
    logic [3:0]         fmt_sel;
    logic               slave_ack;
    logic               timeout_hit;
    logic [DATA_W-1:0]  rd_word;
    logic               err_event;
    logic [ADDR_W-1:0]  err_event_addr;

    assign req         = ld_req_i | st_req_i;
    assign slave_ack   = |(s_ack_i & sel_o);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign rd_word     = s_r_data_i[sel_idx*DATA_W +: DATA_W];

    // Address decode: scan from the top so the lowest matching index wins.
    always_comb begin
        dec_hit = 1'b0;
        dec_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) ==
                (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
                dec_hit = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    // Alignment check and store lane formatting; a store wins over a load.
    always_comb begin
        misalign = |addr_i[1:0];
        fmt_data = '0;
        fmt_sel  = 4'b1111;
        if (st_req_i) begin
            case (st_ops_i)
                ST_OPS_SB: begin
                    misalign = 1'b0;
                    fmt_data = {4{w_data_i[7:0]}};
                    fmt_sel  = 4'b0001 << addr_i[1:0];
                end
                ST_OPS_SH: begin
                    misalign = addr_i[0];
                    fmt_data = {2{w_data_i[15:0]}};
                    fmt_sel  = addr_i[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    fmt_data = w_data_i;
                    fmt_sel  = 4'b1111;
                end
            endcase
        end
    end

    // Error events feeding the sticky register: decode errors in IDLE, timeouts in BUSY.
    always_comb begin
        err_event      = 1'b0;
        err_event_addr = addr_o;
        if (state == IDLE && req && (!dec_hit || misalign)) begin
            err_event      = 1'b1;
            err_event_addr = addr_i;
        end else if (state == BUSY && !slave_ack && timeout_hit) begin
            err_event = 1'b1;
        end
    end

    // Transaction FSM with registered bus and response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel_idx    <= '0;
            cnt        <= '0;
            ack_o      <= 1'b0;
            r_data_o   <= '0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            w_en_o     <= 1'b0;
            addr_o     <= '0;
            w_data_o   <= '0;
            sel_byte_o <= '0;
            sel_o      <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_o     <= addr_i;
                        w_en_o     <= st_req_i;
                        w_data_o   <= fmt_data;
                        sel_byte_o <= fmt_sel;
                        sel_idx    <= dec_idx;
                        cnt        <= '0;
                        if (!dec_hit || misalign) begin
                            state      <= RESP;
                            ack_o      <= 1'b1;
                            err_o      <= 1'b1;
                            err_code_o <= !dec_hit ? ERR_UNMAPPED : ERR_MISALIGN;
                            r_data_o   <= '0;
                        end else begin
                            state <= BUSY;
                            cyc_o <= 1'b1;
                            stb_o <= 1'b1;
                            sel_o <= NUM_SLAVES'(1) << dec_idx;
                        end
                    end
                end
                BUSY: begin
                    if (slave_ack || timeout_hit) begin
                        state      <= RESP;
                        ack_o      <= 1'b1;
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        sel_o      <= '0;
                        err_o      <= !slave_ack;
                        err_code_o <= slave_ack ? ERR_NONE : ERR_TIMEOUT;
                        r_data_o   <= slave_ack ? rd_word : '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky first-error capture; a new error beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
        end else if (err_event && (!err_valid_o || err_clr_i)) begin
            err_valid_o <= 1'b1;
            err_addr_o  <= err_event_addr;
        end else if (err_clr_i) begin
            err_valid_o <= 1'b0;
        end
    end

endmodule
